click_classifier: RTL and testbench

- Sits directly downstream of the push-button debouncer. It consumes that stage's clean one-cycle press pulse.
- Classifies presses into single-click and double-click events by timing the gap between successive pulses against a programmable window.
- Emits one-cycle event strobes, a wrapping event counter and a busy flag to the control logic that selects game/display modes.

---
 rtl/click_pkg.sv | 22 ++
 rtl/window_timer.sv | 45 ++++
 rtl/click_classifier.sv | 153 +++++++++++++++
 tb/tb_click_classifier.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/click_pkg.sv
// click_pkg
//   Shared definitions for click_classifier: FSM state encoding, the default
//   gesture window and the timer-width helper used by the top and the timer.
//   Ports: none (package).
package click_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT2 = 2'd1,
      ST_WAIT3 = 2'd2
   } state_e;

   // 0.5 s at 100 MHz.
   localparam int unsigned DEFAULT_WINDOW = 50_000_000;

   // Timer width; clamped to 1 so an illegal WINDOW still elaborates and the
   // configuration check in the top can report it.
   function automatic int unsigned cnt_width(input int unsigned window);
      return (window < 2) ? 1 : $clog2(window);
   endfunction

endpackage

// File: rtl/window_timer.sv
// window_timer
//   Gap timer shared by all waiting states of click_classifier. Counts up while
//   enabled, clears synchronously, and flags done when the count sits at
//   WINDOW-1 (the last edge at which a follow-up pulse is still accepted).
//   Ports:
//     clk_i   system clock
//     rst_i   synchronous active-high reset
//     clr_i   synchronous clear (priority over en_i)
//     en_i    count enable
//     done_o  combinational: count == WINDOW-1
module window_timer #(
   parameter int unsigned WINDOW = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic done_o
);

   localparam int unsigned CNT_W = click_pkg::cnt_width(WINDOW);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign done_o = (count_q == LAST);

endmodule

// File: rtl/click_classifier.sv
// click_classifier
//   Classifies debounced press pulses into single / double (and optionally
//   triple) click gestures by timing the gap between pulses against WINDOW.
//   Optional feature macro: CLICK_TRIPLE_EN (adds WAIT3 and triple detection;
//   a double is then reported only after the WAIT3 timeout).
//   Ports:
//     clk          system clock
//     rst          synchronous active-high reset
//     pulse_in     one-cycle press pulse from the debouncer
//     single_out   one-cycle strobe, single click
//     double_out   one-cycle strobe, double click
//     triple_out   one-cycle strobe, triple click (0 without CLICK_TRIPLE_EN)
//     busy         high while a gesture is being timed
//     event_count  classified gestures, wraps 255 -> 0
module click_classifier
   import click_pkg::*;
#(
   parameter int unsigned WINDOW = DEFAULT_WINDOW
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pulse_in,
   output logic       single_out,
   output logic       double_out,
   output logic       triple_out,
   output logic       busy,
   output logic [7:0] event_count
);

   initial begin
      if (WINDOW < 2) begin
         $error("click_classifier: WINDOW must be >= 2 (got %0d)", WINDOW);
      end
   end

   state_e     state_q, state_d;
   logic       single_q, single_d;
   logic       double_q, double_d;
   logic       triple_q, triple_d;
   logic [7:0] count_q, count_d;
   logic       tmr_clr, tmr_en, tmr_done;

   window_timer #(
      .WINDOW (WINDOW)
   ) u_timer (
      .clk_i  (clk),
      .rst_i  (rst),
      .clr_i  (tmr_clr),
      .en_i   (tmr_en),
      .done_o (tmr_done)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state. A pulse always wins over a simultaneous timeout.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (pulse_in) state_d = ST_WAIT2;
         end
         ST_WAIT2: begin
`ifdef CLICK_TRIPLE_EN
            if (pulse_in) state_d = ST_WAIT3;
`else
            if (pulse_in) state_d = ST_IDLE;
`endif
            else if (tmr_done) state_d = ST_IDLE;
         end
`ifdef CLICK_TRIPLE_EN
         ST_WAIT3: begin
            if (pulse_in || tmr_done) state_d = ST_IDLE;
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // Strobe next-values and timer control. The timer is held clear in IDLE so
   // a gesture always starts from 0 on the edge that sees its first pulse.
   always_comb begin
      single_d = 1'b0;
      double_d = 1'b0;
      triple_d = 1'b0;
      tmr_clr  = 1'b0;
      tmr_en   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            tmr_clr = 1'b1;
         end
         ST_WAIT2: begin
            if (pulse_in) begin
`ifdef CLICK_TRIPLE_EN
               tmr_clr  = 1'b1;
`else
               double_d = 1'b1;
`endif
            end else if (tmr_done) begin
               single_d = 1'b1;
            end else begin
               tmr_en = 1'b1;
            end
         end
`ifdef CLICK_TRIPLE_EN
         ST_WAIT3: begin
            if (pulse_in) begin
               triple_d = 1'b1;
            end else if (tmr_done) begin
               double_d = 1'b1;
            end else begin
               tmr_en = 1'b1;
            end
         end
`endif
         default: ;
      endcase
   end

   always_comb begin
      count_d = count_q;
      if (single_d || double_d || triple_d) begin
         count_d = count_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         single_q <= 1'b0;
         double_q <= 1'b0;
         triple_q <= 1'b0;
         count_q  <= 8'd0;
      end else begin
         single_q <= single_d;
         double_q <= double_d;
         triple_q <= triple_d;
         count_q  <= count_d;
      end
   end

   assign single_out  = single_q;
   assign double_out  = double_q;
   assign triple_out  = triple_q;
   assign busy        = (state_q != ST_IDLE);
   assign event_count = count_q;

endmodule

// File: tb/tb_click_classifier.sv
// tb_click_classifier
//   Self-checking bench for click_classifier with WINDOW = 8. A time-based
//   gesture model (pulse count + cycle of last pulse) predicts every output
//   after every edge; directed sequences add literal expectations on top.
module tb_click_classifier;

   localparam int unsigned WIN = 8;
`ifdef CLICK_TRIPLE_EN
   localparam int MAX_N = 3;
`else
   localparam int MAX_N = 2;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pulse_in = 1'b0;
   logic       single_out, double_out, triple_out, busy;
   logic [7:0] event_count;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // Model state.
   bit         m_active = 1'b0;
   int         m_n      = 0;
   int         m_last   = 0;
   logic [7:0] m_count  = 8'd0;
   logic       e_single, e_double, e_triple;

   click_classifier #(
      .WINDOW (WIN)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pulse_in    (pulse_in),
      .single_out  (single_out),
      .double_out  (double_out),
      .triple_out  (triple_out),
      .busy        (busy),
      .event_count (event_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic emit(input int n);
      e_single = (n == 1);
      e_double = (n == 2);
      e_triple = (n == 3);
      m_active = 1'b0;
      m_count  = m_count + 8'd1;
   endtask

   // One edge of the gesture rules: a follow-up pulse counts if it lands
   // within WIN edges of the previous one; otherwise the gesture closes
   // exactly WIN edges after its last pulse.
   task automatic model_step(input logic p, input logic r);
      e_single = 1'b0;
      e_double = 1'b0;
      e_triple = 1'b0;
      if (r) begin
         m_active = 1'b0;
         m_count  = 8'd0;
      end else if (!m_active) begin
         if (p) begin
            m_active = 1'b1;
            m_n      = 1;
            m_last   = cyc;
         end
      end else if (p) begin
         m_n    = m_n + 1;
         m_last = cyc;
         if (m_n == MAX_N) emit(m_n);
      end else if (cyc - m_last == int'(WIN)) begin
         emit(m_n);
      end
   endtask

   // Compare process: inputs change at posedge+2, so at posedge+1 they still
   // hold the values the DUT sampled.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         model_step(pulse_in, rst);
         chk("outputs{s,d,t,busy,cnt}",
             {20'd0, single_out, double_out, triple_out, busy, event_count},
             {20'd0, e_single, e_double, e_triple, m_active, m_count});
      end
   end

   task automatic tick(input logic p, input logic r);
      pulse_in = p;
      rst      = r;
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_strobes", {29'd0, single_out, double_out, triple_out}, 32'd0);
      chk("reset_count", {24'd0, event_count}, 32'd0);
   endtask

   initial begin
      // Single click: strobe exactly WIN edges after the pulse.
      do_reset();
      tick(1'b1, 1'b0);
      chk("t1_busy_after_pulse", {31'd0, busy}, 32'd1);
      for (int i = 1; i <= int'(WIN); i++) begin
         tick(1'b0, 1'b0);
         chk("t1_single_timing", {31'd0, single_out}, (i == int'(WIN)) ? 32'd1 : 32'd0);
         chk("t1_busy_timing", {31'd0, busy}, (i < int'(WIN)) ? 32'd1 : 32'd0);
      end
      chk("t1_count", {24'd0, event_count}, 32'd1);

`ifndef CLICK_TRIPLE_EN
      // Double at t+3.
      do_reset();
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      chk("t2_double", {31'd0, double_out}, 32'd1);
      chk("t2_no_single", {31'd0, single_out}, 32'd0);
      chk("t2_idle", {31'd0, busy}, 32'd0);
      chk("t2_count", {24'd0, event_count}, 32'd1);

      // Second pulse on the boundary edge t+8 still counts.
      do_reset();
      tick(1'b1, 1'b0);
      repeat (WIN - 1) tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      chk("t3_boundary_double", {31'd0, double_out}, 32'd1);
      chk("t3_boundary_no_single", {31'd0, single_out}, 32'd0);
`else
      // Triple at t, t+2, t+5.
      do_reset();
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      chk("t2_triple", {31'd0, triple_out}, 32'd1);
      chk("t2_count", {24'd0, event_count}, 32'd1);

      // Double at t, t+2 reported at edge t+10.
      do_reset();
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      for (int i = 1; i <= int'(WIN); i++) begin
         tick(1'b0, 1'b0);
         chk("t3_late_double", {31'd0, double_out}, (i == int'(WIN)) ? 32'd1 : 32'd0);
      end
      chk("t3_count", {24'd0, event_count}, 32'd1);
`endif

      // Pulse at t+9: single closes at t+8, new gesture starts at t+9.
      do_reset();
      tick(1'b1, 1'b0);
      repeat (WIN) tick(1'b0, 1'b0);
      chk("t4_single", {31'd0, single_out}, 32'd1);
      tick(1'b1, 1'b0);
      chk("t4_new_gesture_busy", {31'd0, busy}, 32'd1);
      repeat (WIN) tick(1'b0, 1'b0);
      chk("t4_second_single", {31'd0, single_out}, 32'd1);
      chk("t4_count", {24'd0, event_count}, 32'd2);

      // Reset mid-gesture drops the click.
      do_reset();
      tick(1'b1, 1'b0);
      repeat (3) tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
      chk("t5_busy_after_rst", {31'd0, busy}, 32'd0);
      repeat (WIN + 2) tick(1'b0, 1'b0);
      chk("t5_count", {24'd0, event_count}, 32'd0);

      // 256 back-to-back singles, each starting on the first IDLE edge.
      do_reset();
      for (int g = 0; g < 256; g++) begin
         tick(1'b1, 1'b0);
         repeat (WIN) tick(1'b0, 1'b0);
         if (g == 254) chk("t6_count_255", {24'd0, event_count}, 32'd255);
      end
      chk("t6_wrap", {24'd0, event_count}, 32'd0);
      chk("t6_idle", {31'd0, busy}, 32'd0);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
      end
      repeat (3 * WIN) tick(1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete (got timeout, expected finish)");
      $fatal(1);
   end

endmodule
